// File: rtl/aes_dma_pkg.sv
// Shared definitions for the AES-128 counter-mode DMA engine.
// Holds the FSM state encoding (visible to software through STATUS[1:0]),
// the byte offsets of the CPU register window and the window/block sizes.
package aes_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_OPERATE = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    localparam logic [5:0] OFF_CMD    = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_SRC    = 6'h02;
    localparam logic [5:0] OFF_DST    = 6'h04;
    localparam logic [5:0] OFF_LEN    = 6'h06;
    localparam logic [5:0] OFF_KEY    = 6'h10;
    localparam logic [5:0] OFF_CTR    = 6'h20;

    localparam int unsigned WIN_SIZE = 48;
    localparam int unsigned BLK_SIZE = 16;

endpackage

// File: rtl/aes_dma_regfile.sv
// CPU-side register file of the AES-CTR DMA engine.
// Decodes the 48-byte window at BASE, stores SRC/DST/LEN/KEY/CTR
// (little-endian, writable only while the engine is idle), drives the
// combinational read mux and turns CMD/STATUS writes into one-cycle strobes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   addr/data_in/wr/stb CPU bus request; data_out/ack CPU bus response
//   idle/state/done/aborted  engine status for write gating and STATUS reads
//   start_cmd/abort_cmd CMD bit0/bit1 write strobes
//   clr_done/clr_aborted STATUS write-one-to-clear strobes
//   src/dst/len/key/ctr configuration register contents
module aes_dma_regfile
    import aes_dma_pkg::*;
#(
    parameter logic [15:0] BASE = 16'hff00
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  addr,
    input  logic [7:0]   data_in,
    input  logic         wr,
    input  logic         stb,
    input  logic         idle,
    input  logic [1:0]   state,
    input  logic         done,
    input  logic         aborted,
    output logic [7:0]   data_out,
    output logic         ack,
    output logic         start_cmd,
    output logic         abort_cmd,
    output logic         clr_done,
    output logic         clr_aborted,
    output logic [15:0]  src,
    output logic [15:0]  dst,
    output logic [15:0]  len,
    output logic [127:0] key,
    output logic [127:0] ctr
);

    logic [16:0] win_lo;
    logic [16:0] win_hi;
    logic [5:0]  off;
    logic        cpu_we;
    logic        cfg_we;

    // 17-bit bounds so a window placed at the top of the address space
    // does not wrap around.
    assign win_lo = {1'b0, BASE};
    assign win_hi = win_lo + 17'(WIN_SIZE);
    assign ack    = stb && ({1'b0, addr} >= win_lo) && ({1'b0, addr} < win_hi);
    assign off    = 6'(addr - BASE);

    assign cpu_we      = ack && wr;
    assign cfg_we      = cpu_we && idle;
    assign start_cmd   = cpu_we && (off == OFF_CMD)    && data_in[0];
    assign abort_cmd   = cpu_we && (off == OFF_CMD)    && data_in[1];
    assign clr_done    = cpu_we && (off == OFF_STATUS) && data_in[2];
    assign clr_aborted = cpu_we && (off == OFF_STATUS) && data_in[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            src <= '0;
            dst <= '0;
            len <= '0;
            key <= '0;
            ctr <= '0;
        end else if (cfg_we) begin
            case (off)
                OFF_SRC:          src[7:0]  <= data_in;
                OFF_SRC + 6'd1:   src[15:8] <= data_in;
                OFF_DST:          dst[7:0]  <= data_in;
                OFF_DST + 6'd1:   dst[15:8] <= data_in;
                OFF_LEN:          len[7:0]  <= data_in;
                OFF_LEN + 6'd1:   len[15:8] <= data_in;
                default: begin
                    // off[5:4] selects the 16-byte KEY (01) or CTR (10) bank
                    if (off[5:4] == 2'b01)
                        key[{off[3:0], 3'b000} +: 8] <= data_in;
                    else if (off[5:4] == 2'b10)
                        ctr[{off[3:0], 3'b000} +: 8] <= data_in;
                end
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        if (ack) begin
            case (off)
                OFF_STATUS:     data_out = {4'b0000, aborted, done, state};
                OFF_SRC:        data_out = src[7:0];
                OFF_SRC + 6'd1: data_out = src[15:8];
                OFF_DST:        data_out = dst[7:0];
                OFF_DST + 6'd1: data_out = dst[15:8];
                OFF_LEN:        data_out = len[7:0];
                OFF_LEN + 6'd1: data_out = len[15:8];
                default: begin
                    if (off[5:4] == 2'b01)
                        data_out = key[{off[3:0], 3'b000} +: 8];
                    else if (off[5:4] == 2'b10)
                        data_out = ctr[{off[3:0], 3'b000} +: 8];
                end
            endcase
        end
    end

endmodule

// File: rtl/aes_ctr_dma.sv
// Memory-mapped AES-128 counter-mode DMA engine for the oc8051 XRAM bus.
// Reads up to 16 bytes from SRC, waits OP_CYCLES for the external AES core,
// XORs the keystream into the block and writes it to DST; repeats with the
// counter advanced by CTR_STEP until LEN bytes are done (last block partial).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   addr/data_in/data_out/wr/stb/ack   CPU register window at BASE
//   xram_*                         DMA master port (one byte per xram_ack)
//   core_ctr/core_key/core_out     external AES core interface
//   irq                            level, mirrors the sticky DONE flag
//   busy                           engine not idle
module aes_ctr_dma
    import aes_dma_pkg::*;
#(
    parameter logic [15:0]  BASE      = 16'hff00,
    parameter int unsigned  OP_CYCLES = 20,
    parameter logic [127:0] CTR_STEP  = 128'd16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  addr,
    input  logic [7:0]   data_in,
    output logic [7:0]   data_out,
    input  logic         wr,
    input  logic         stb,
    output logic         ack,
    output logic [15:0]  xram_addr,
    output logic [7:0]   xram_data_out,
    input  logic [7:0]   xram_data_in,
    output logic         xram_stb,
    output logic         xram_wr,
    input  logic         xram_ack,
    output logic [127:0] core_ctr,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         irq,
    output logic         busy
);

    state_t       state;
    logic [3:0]   byte_cnt;
    logic [16:0]  blk_off;
    logic [16:0]  rem;
    logic [7:0]   timer;
    logic [127:0] wctr;
    logic [127:0] in_buf;
    logic [127:0] out_buf;
    logic         done;
    logic         aborted;
    logic         last_byte;

    logic         start_cmd;
    logic         abort_cmd;
    logic         clr_done;
    logic         clr_aborted;
    logic [15:0]  src;
    logic [15:0]  dst;
    logic [15:0]  len;
    logic [127:0] key;
    logic [127:0] ctr;

    aes_dma_regfile #(
        .BASE(BASE)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .data_in     (data_in),
        .wr          (wr),
        .stb         (stb),
        .idle        (state == ST_IDLE),
        .state       (state),
        .done        (done),
        .aborted     (aborted),
        .data_out    (data_out),
        .ack         (ack),
        .start_cmd   (start_cmd),
        .abort_cmd   (abort_cmd),
        .clr_done    (clr_done),
        .clr_aborted (clr_aborted),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .key         (key),
        .ctr         (ctr)
    );

    // Bytes still to move from the current block start; 17 bits so that
    // blk_off stepping past a LEN near 0xFFFF still compares correctly.
    assign rem       = {1'b0, len} - blk_off;
    assign last_byte = (rem >= 17'(BLK_SIZE)) ? (byte_cnt == 4'hF)
                                              : ({13'b0, byte_cnt} == rem - 17'd1);

    assign xram_stb      = (state == ST_READ) || (state == ST_WRITE);
    assign xram_wr       = (state == ST_WRITE);
    assign xram_addr     = ((state == ST_WRITE) ? dst : src) + blk_off[15:0] + {12'b0, byte_cnt};
    assign xram_data_out = out_buf[{byte_cnt, 3'b000} +: 8];
    assign core_ctr      = wctr;
    assign core_key      = key;
    assign irq           = done;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            blk_off  <= '0;
            timer    <= '0;
            wctr     <= '0;
            in_buf   <= '0;
            out_buf  <= '0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            if (clr_done)
                done <= 1'b0;
            if (clr_aborted)
                aborted <= 1'b0;

            // ABORT overrides everything, including a START in the same
            // write and any xram_ack arriving in this cycle.
            if (abort_cmd) begin
                state   <= ST_IDLE;
                aborted <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_cmd) begin
                            if (len == 16'd0) begin
                                done <= 1'b1;
                            end else begin
                                state    <= ST_READ;
                                byte_cnt <= '0;
                                blk_off  <= '0;
                                wctr     <= ctr;
                                done     <= 1'b0;
                                aborted  <= 1'b0;
                            end
                        end
                    end
                    ST_READ: begin
                        if (xram_ack) begin
                            in_buf[{byte_cnt, 3'b000} +: 8] <= xram_data_in;
                            if (last_byte) begin
                                state    <= ST_OPERATE;
                                byte_cnt <= '0;
                                timer    <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + 4'd1;
                            end
                        end
                    end
                    ST_OPERATE: begin
                        if (timer != 8'hFF)
                            timer <= timer + 8'd1;
                        if (timer == 8'(OP_CYCLES - 1)) begin
                            out_buf <= core_out ^ in_buf;
                            state   <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        if (xram_ack) begin
                            if (last_byte) begin
                                if (blk_off + 17'(BLK_SIZE) < {1'b0, len}) begin
                                    blk_off  <= blk_off + 17'(BLK_SIZE);
                                    wctr     <= wctr + CTR_STEP;
                                    byte_cnt <= '0;
                                    state    <= ST_READ;
                                end else begin
                                    state <= ST_IDLE;
                                    done  <= 1'b1;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 4'd1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
